// File: rtl/id_stage_if.sv
// Fetch-to-decode-to-execute handshake bundle for the RV32I decode stage.
// The master side is the environment (fetch source and execute sink);
// the slave side is the decode stage itself.
interface id_stage_if #(
  parameter int XLEN = 32
);
  // Pipeline control
  logic            flush;

  // Fetch side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  // Execute side
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_ctrl;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output flush,
    output in_valid,
    output in_instr,
    output in_pc,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_ctrl,
    input  out_imm,
    input  out_rs1,
    input  out_rs2,
    input  out_rd,
    input  out_funct3,
    input  out_pc,
    input  out_illegal
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_instr,
    input  in_pc,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_ctrl,
    output out_imm,
    output out_rs1,
    output out_rs2,
    output out_rd,
    output out_funct3,
    output out_pc,
    output out_illegal
  );
endinterface

// File: rtl/id_stage.sv
// Registered RV32I instruction-decode stage.
// Decodes one instruction per cycle into a control bundle, a sign-extended
// immediate and register indices, with valid/ready handshaking, an optional
// 2-entry skid buffer, flush, illegal detection and optional M decode.
// Note: rst_n is active-high despite its name (1 = reset).
module id_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter bit SKID     = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  id_stage_if.slave bus
);

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // R-type funct7 classes
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // funct3 values with special meaning
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Control bundle bit positions
  localparam int C_ALU_SRC_IMM = 4;
  localparam int C_REG_WRITE   = 5;
  localparam int C_MEM_TO_REG  = 6;
  localparam int C_MEM_WRITE   = 7;
  localparam int C_MEM_READ    = 8;
  localparam int C_BRANCH      = 9;
  localparam int C_JALR        = 10;
  localparam int C_JAL         = 11;
  localparam int C_BRANCH_NE   = 12;
  localparam int C_MUL         = 13;
  localparam int C_LUI         = 14;
  localparam int C_AUIPC       = 15;

  // One decoded instruction as it is held in the output or skid register
  typedef struct packed {
    logic [15:0]     ctrl;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [15:0] ctrl_raw;
  logic [31:0] imm_sel;
  logic        illegal;
  logic        reg_write;
  bundle_t     dec;

  bundle_t     out_q;
  logic        out_valid_q;
  logic        in_ready_w;

  assign opcode   = bus.in_instr[6:0];
  assign funct3   = bus.in_instr[14:12];
  assign funct7   = bus.in_instr[31:25];
  assign rd_field = bus.in_instr[11:7];

  // Raw 32-bit immediates for each format; widened to XLEN by sign extension
  assign imm_i = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_s = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
  assign imm_b = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                  bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
  assign imm_u = {bus.in_instr[31:12], 12'b0};
  assign imm_j = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                  bus.in_instr[20], bus.in_instr[30:21], 1'b0};

  // Per-opcode control decode, immediate selection and illegal detection
  always_comb begin
    ctrl_raw = '0;
    imm_sel  = '0;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          ctrl_raw[3:0]         = {1'b0, funct3};
          ctrl_raw[C_REG_WRITE] = 1'b1;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD || funct3 == F3_SRL) begin
            ctrl_raw[3:0]         = {1'b1, funct3};
            ctrl_raw[C_REG_WRITE] = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct7 == F7_MUL && ENABLE_M) begin
          ctrl_raw[C_MUL]       = 1'b1;
          ctrl_raw[C_REG_WRITE] = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        ctrl_raw[3:0]           = {(funct3 == F3_SRL) & funct7[5], funct3};
        ctrl_raw[C_ALU_SRC_IMM] = 1'b1;
        ctrl_raw[C_REG_WRITE]   = 1'b1;
        imm_sel                 = imm_i;
      end
      OPC_LOAD: begin
        ctrl_raw[C_ALU_SRC_IMM] = 1'b1;
        ctrl_raw[C_REG_WRITE]   = 1'b1;
        ctrl_raw[C_MEM_TO_REG]  = 1'b1;
        ctrl_raw[C_MEM_READ]    = 1'b1;
        imm_sel                 = imm_i;
      end
      OPC_STORE: begin
        ctrl_raw[C_ALU_SRC_IMM] = 1'b1;
        ctrl_raw[C_MEM_WRITE]   = 1'b1;
        imm_sel                 = imm_s;
      end
      OPC_BRANCH: begin
        ctrl_raw[C_BRANCH]    = 1'b1;
        ctrl_raw[C_BRANCH_NE] = (funct3 == F3_BNE);
        imm_sel               = imm_b;
        illegal               = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
      end
      OPC_JAL: begin
        ctrl_raw[C_JAL]       = 1'b1;
        ctrl_raw[C_REG_WRITE] = 1'b1;
        imm_sel               = imm_j;
      end
      OPC_JALR: begin
        ctrl_raw[C_JALR]        = 1'b1;
        ctrl_raw[C_REG_WRITE]   = 1'b1;
        ctrl_raw[C_ALU_SRC_IMM] = 1'b1;
        imm_sel                 = imm_i;
      end
      OPC_LUI: begin
        ctrl_raw[C_LUI]       = 1'b1;
        ctrl_raw[C_REG_WRITE] = 1'b1;
        imm_sel               = imm_u;
      end
      OPC_AUIPC: begin
        ctrl_raw[C_AUIPC]     = 1'b1;
        ctrl_raw[C_REG_WRITE] = 1'b1;
        imm_sel               = imm_u;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Writes to x0 are dropped, illegal encodings carry no control, and rd is
  // only reported when something will actually be written back
  always_comb begin
    dec                  = '0;
    reg_write            = ctrl_raw[C_REG_WRITE] && (rd_field != 5'd0) && !illegal;
    dec.ctrl             = illegal ? 16'h0000 : ctrl_raw;
    dec.ctrl[C_REG_WRITE] = reg_write;
    dec.imm              = XLEN'($signed(imm_sel));
    dec.rs1              = bus.in_instr[19:15];
    dec.rs2              = bus.in_instr[24:20];
    dec.rd               = reg_write ? rd_field : 5'd0;
    dec.funct3           = funct3;
    dec.pc               = bus.in_pc;
    dec.illegal          = illegal;
  end

  generate
    if (SKID) begin : g_skid
      bundle_t skid_q;
      logic    skid_valid_q;
      logic    in_ready_q;
      logic    in_fire;
      logic    out_fire;

      assign in_fire  = bus.in_valid & in_ready_q;
      assign out_fire = out_valid_q & bus.out_ready;

      // Output register plus one skid entry; the skid entry refills the output
      // whenever the output drains, so order is kept across back-pressure
      always_ff @(posedge clk) begin
        if (rst_n) begin
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
          in_ready_q   <= 1'b0;
          out_q        <= '0;
          skid_q       <= '0;
        end else if (bus.flush) begin
          out_valid_q  <= 1'b0;
          skid_valid_q <= 1'b0;
          in_ready_q   <= 1'b1;
        end else if (out_fire || !out_valid_q) begin
          if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            if (in_fire) begin
              skid_q <= dec;
            end
            skid_valid_q <= in_fire;
            in_ready_q   <= !in_fire;
          end else begin
            if (in_fire) begin
              out_q <= dec;
            end
            out_valid_q <= in_fire;
            in_ready_q  <= 1'b1;
          end
        end else if (in_fire) begin
          skid_q       <= dec;
          skid_valid_q <= 1'b1;
          in_ready_q   <= 1'b0;
        end
      end

      assign in_ready_w = in_ready_q;
    end else begin : g_noskid
      logic in_fire;
      logic out_fire;

      assign in_ready_w = !rst_n && (!out_valid_q || bus.out_ready);
      assign in_fire    = bus.in_valid & in_ready_w;
      assign out_fire   = out_valid_q & bus.out_ready;

      // Single output register; a simultaneous in/out transfer replaces it
      always_ff @(posedge clk) begin
        if (rst_n) begin
          out_valid_q <= 1'b0;
          out_q       <= '0;
        end else if (bus.flush) begin
          out_valid_q <= 1'b0;
        end else if (in_fire) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
        end else if (out_fire) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_ctrl    = out_q.ctrl;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: decode values, skid back-pressure,
// flush, mid-stream reset, and a second instance without M and skid.
module tb_id_stage;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   failures;

  id_stage_if #(.XLEN(32)) bus_a ();
  id_stage_if #(.XLEN(32)) bus_b ();

  id_stage #(.XLEN(32), .ENABLE_M(1'b1), .SKID(1'b1)) dut_a (
    .clk  (clk),
    .rst_n(rst_a),
    .bus  (bus_a)
  );

  id_stage #(.XLEN(32), .ENABLE_M(1'b0), .SKID(1'b0)) dut_b (
    .clk  (clk),
    .rst_n(rst_b),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic rdy, input logic fl);
    bus_a.in_valid  = v;
    bus_a.in_instr  = instr;
    bus_a.in_pc     = pc;
    bus_a.out_ready = rdy;
    bus_a.flush     = fl;
  endtask

  task automatic applyStimulusB(input logic v, input logic [31:0] instr,
                                input logic [31:0] pc, input logic rdy);
    bus_b.in_valid  = v;
    bus_b.in_instr  = instr;
    bus_b.in_pc     = pc;
    bus_b.out_ready = rdy;
    bus_b.flush     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulusB(1'b0, 32'h0, 32'h0, 1'b1);

    // Reset state
    tick();
    checkOutput("rst_in_ready", bus_a.in_ready, 1'b0);
    checkOutput("rst_out_valid", bus_a.out_valid, 1'b0);
    checkOutput("rst_ctrl", bus_a.out_ctrl, 16'h0000);
    checkOutput("rst_pc", bus_a.out_pc, 32'h0);
    checkOutput("b_rst_in_ready", bus_b.in_ready, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", bus_a.in_ready, 1'b1);
    checkOutput("post_rst_out_valid", bus_a.out_valid, 1'b0);
    checkOutput("b_post_rst_in_ready", bus_b.in_ready, 1'b1);

    // addi x1,x0,5
    applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    tick();
    checkOutput("addi_valid", bus_a.out_valid, 1'b1);
    checkOutput("addi_ctrl", bus_a.out_ctrl, 16'h0030);
    checkOutput("addi_imm", bus_a.out_imm, 32'h5);
    checkOutput("addi_rd", bus_a.out_rd, 5'd1);
    checkOutput("addi_illegal", bus_a.out_illegal, 1'b0);
    checkOutput("addi_pc", bus_a.out_pc, 32'h100);

    // sw x2,-4(x1)
    applyStimulus(1'b1, 32'hFE20AE23, 32'h104, 1'b1, 1'b0);
    tick();
    checkOutput("sw_ctrl", bus_a.out_ctrl, 16'h0090);
    checkOutput("sw_imm", bus_a.out_imm, 32'hFFFFFFFC);
    checkOutput("sw_rd", bus_a.out_rd, 5'd0);
    checkOutput("sw_rs1", bus_a.out_rs1, 5'd1);
    checkOutput("sw_rs2", bus_a.out_rs2, 5'd2);
    checkOutput("sw_funct3", bus_a.out_funct3, 3'd2);

    // bne x1,x2,+8
    applyStimulus(1'b1, 32'h00209463, 32'h108, 1'b1, 1'b0);
    tick();
    checkOutput("bne_ctrl", bus_a.out_ctrl, 16'h1200);
    checkOutput("bne_imm", bus_a.out_imm, 32'h8);
    checkOutput("bne_rd", bus_a.out_rd, 5'd0);

    // mul x3,x1,x2
    applyStimulus(1'b1, 32'h022081B3, 32'h10C, 1'b1, 1'b0);
    tick();
    checkOutput("mul_ctrl", bus_a.out_ctrl, 16'h2020);
    checkOutput("mul_rd", bus_a.out_rd, 5'd3);
    checkOutput("mul_imm", bus_a.out_imm, 32'h0);
    checkOutput("mul_illegal", bus_a.out_illegal, 1'b0);

    // sub x4,x1,x2
    applyStimulus(1'b1, 32'h40208233, 32'h110, 1'b1, 1'b0);
    tick();
    checkOutput("sub_ctrl", bus_a.out_ctrl, 16'h0028);
    checkOutput("sub_rd", bus_a.out_rd, 5'd4);

    // srai x6,x1,3
    applyStimulus(1'b1, 32'h4030D313, 32'h114, 1'b1, 1'b0);
    tick();
    checkOutput("srai_ctrl", bus_a.out_ctrl, 16'h003D);
    checkOutput("srai_imm", bus_a.out_imm, 32'h403);

    // funct7=0100000 with funct3=001 is illegal
    applyStimulus(1'b1, 32'h40209233, 32'h118, 1'b1, 1'b0);
    tick();
    checkOutput("alt_f3_illegal", bus_a.out_illegal, 1'b1);
    checkOutput("alt_f3_ctrl", bus_a.out_ctrl, 16'h0000);
    checkOutput("alt_f3_rd", bus_a.out_rd, 5'd0);

    // blt is outside the supported branch set
    applyStimulus(1'b1, 32'h0020C463, 32'h11C, 1'b1, 1'b0);
    tick();
    checkOutput("blt_illegal", bus_a.out_illegal, 1'b1);
    checkOutput("blt_ctrl", bus_a.out_ctrl, 16'h0000);

    // unknown opcode
    applyStimulus(1'b1, 32'h0000007F, 32'h120, 1'b1, 1'b0);
    tick();
    checkOutput("unk_illegal", bus_a.out_illegal, 1'b1);
    checkOutput("unk_pc", bus_a.out_pc, 32'h120);

    // nop writes x0, so reg_write clears
    applyStimulus(1'b1, 32'h00000013, 32'h124, 1'b1, 1'b0);
    tick();
    checkOutput("nop_ctrl", bus_a.out_ctrl, 16'h0010);
    checkOutput("nop_illegal", bus_a.out_illegal, 1'b0);

    // jal x1,+16
    applyStimulus(1'b1, 32'h010000EF, 32'h128, 1'b1, 1'b0);
    tick();
    checkOutput("jal_ctrl", bus_a.out_ctrl, 16'h0820);
    checkOutput("jal_imm", bus_a.out_imm, 32'h10);
    checkOutput("jal_rd", bus_a.out_rd, 5'd1);

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain_valid", bus_a.out_valid, 1'b0);

    // Back-pressure: A, B, C with out_ready low for four cycles
    applyStimulus(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
    tick();
    checkOutput("skid_a_pc", bus_a.out_pc, 32'h200);
    checkOutput("skid_a_in_ready", bus_a.in_ready, 1'b1);
    applyStimulus(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
    tick();
    checkOutput("skid_full_in_ready", bus_a.in_ready, 1'b0);
    checkOutput("skid_hold1_pc", bus_a.out_pc, 32'h200);
    applyStimulus(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
    tick();
    checkOutput("skid_hold2_pc", bus_a.out_pc, 32'h200);
    checkOutput("skid_hold2_imm", bus_a.out_imm, 32'h1);
    tick();
    checkOutput("skid_hold3_pc", bus_a.out_pc, 32'h200);
    checkOutput("skid_hold3_valid", bus_a.out_valid, 1'b1);
    applyStimulus(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
    tick();
    checkOutput("skid_b_pc", bus_a.out_pc, 32'h204);
    checkOutput("skid_b_imm", bus_a.out_imm, 32'h2);
    tick();
    checkOutput("skid_c_pc", bus_a.out_pc, 32'h208);
    checkOutput("skid_c_imm", bus_a.out_imm, 32'h3);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("skid_done_valid", bus_a.out_valid, 1'b0);

    // Flush with skid full, then flush with a same-cycle accepted input
    applyStimulus(1'b1, 32'h00400213, 32'h300, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00500293, 32'h304, 1'b0, 1'b0);
    tick();
    checkOutput("pre_flush_in_ready", bus_a.in_ready, 1'b0);
    applyStimulus(1'b1, 32'h00600313, 32'h308, 1'b0, 1'b1);
    tick();
    checkOutput("flush_valid", bus_a.out_valid, 1'b0);
    checkOutput("flush_in_ready", bus_a.in_ready, 1'b1);
    applyStimulus(1'b1, 32'h00700393, 32'h30C, 1'b0, 1'b1);
    tick();
    checkOutput("flush_drop_valid", bus_a.out_valid, 1'b0);
    applyStimulus(1'b1, 32'h00800413, 32'h310, 1'b1, 1'b0);
    tick();
    checkOutput("after_flush_pc", bus_a.out_pc, 32'h310);
    checkOutput("after_flush_valid", bus_a.out_valid, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("after_flush_drain", bus_a.out_valid, 1'b0);

    // Reset mid-stream with both entries full
    applyStimulus(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00200113, 32'h404, 1'b0, 1'b0);
    tick();
    rst_a = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("mrst_valid", bus_a.out_valid, 1'b0);
    checkOutput("mrst_in_ready", bus_a.in_ready, 1'b0);
    checkOutput("mrst_ctrl", bus_a.out_ctrl, 16'h0000);
    checkOutput("mrst_imm", bus_a.out_imm, 32'h0);
    checkOutput("mrst_pc", bus_a.out_pc, 32'h0);
    checkOutput("mrst_rs1", bus_a.out_rs1, 5'd0);
    checkOutput("mrst_funct3", bus_a.out_funct3, 3'd0);
    rst_a = 1'b0;
    tick();
    checkOutput("mrst_release_in_ready", bus_a.in_ready, 1'b1);
    checkOutput("mrst_release_valid", bus_a.out_valid, 1'b0);

    // lui x5,0x12345 and auipc x6,1
    applyStimulus(1'b1, 32'h123452B7, 32'h500, 1'b1, 1'b0);
    tick();
    checkOutput("lui_ctrl", bus_a.out_ctrl, 16'h4020);
    checkOutput("lui_imm", bus_a.out_imm, 32'h12345000);
    checkOutput("lui_rd", bus_a.out_rd, 5'd5);
    applyStimulus(1'b1, 32'h00001317, 32'h504, 1'b1, 1'b0);
    tick();
    checkOutput("auipc_ctrl", bus_a.out_ctrl, 16'h8020);
    checkOutput("auipc_imm", bus_a.out_imm, 32'h1000);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Instance without M extension and without skid buffer
    applyStimulusB(1'b1, 32'h022081B3, 32'h600, 1'b0);
    tick();
    checkOutput("b_mul_valid", bus_b.out_valid, 1'b1);
    checkOutput("b_mul_illegal", bus_b.out_illegal, 1'b1);
    checkOutput("b_mul_ctrl", bus_b.out_ctrl, 16'h0000);
    checkOutput("b_mul_rd", bus_b.out_rd, 5'd0);
    checkOutput("b_stall_in_ready", bus_b.in_ready, 1'b0);
    applyStimulusB(1'b1, 32'h00500093, 32'h604, 1'b1);
    #1;
    checkOutput("b_release_in_ready", bus_b.in_ready, 1'b1);
    tick();
    checkOutput("b_replace_pc", bus_b.out_pc, 32'h604);
    checkOutput("b_replace_ctrl", bus_b.out_ctrl, 16'h0030);
    applyStimulusB(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("b_drain_valid", bus_b.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
